// File: rtl/alu_op_sequencer.sv
// Issue-side sequencer: forwards single-cycle ops to the datapath one cycle after
// acceptance and runs the multi-cycle DIVU start/step/HiLo-write sequence.
module alu_op_sequencer #(
    parameter int DIV_CYCLES    = 32,
    parameter bit ALLOW_OVERLAP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [5:0] funct,
    output logic       in_ready,
    output logic [5:0] op_out,
    output logic       op_valid,
    output logic       div_start,
    output logic       div_step,
    output logic       hilo_we,
    output logic [5:0] div_count,
    output logic       busy,
    output logic       illegal
);

    localparam logic [5:0] F_SLL  = 6'd0;
    localparam logic [5:0] F_SRL  = 6'd2;
    localparam logic [5:0] F_MFHI = 6'd16;
    localparam logic [5:0] F_MFLO = 6'd18;
    localparam logic [5:0] F_DIVU = 6'd27;
    localparam logic [5:0] F_ADD  = 6'd32;
    localparam logic [5:0] F_SUB  = 6'd34;
    localparam logic [5:0] F_AND  = 6'd36;
    localparam logic [5:0] F_OR   = 6'd37;
    localparam logic [5:0] F_SLT  = 6'd42;
    localparam logic [5:0] HILO_OP    = 6'b111111;
    localparam logic [5:0] LAST_STEP  = 6'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DIV_START = 2'd1,
        DIV_RUN   = 2'd2,
        DIV_WRITE = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic [5:0] count_reg, count_next;
    logic [5:0] op_reg, op_next;
    logic       op_valid_reg, op_valid_next;
    logic       illegal_reg, illegal_next;

    logic is_legal;
    logic uses_hilo;
    logic accept;

    always_comb begin
        is_legal  = 1'b0;
        uses_hilo = 1'b0;
        case (funct)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_SLL: is_legal = 1'b1;
            F_DIVU, F_MFHI, F_MFLO: begin
                is_legal  = 1'b1;
                uses_hilo = 1'b1;
            end
            default: ;
        endcase
    end

    // Ops touching HiLo wait for IDLE; illegal codes stall like ALU ops.
    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            case (state_reg)
                IDLE:               in_ready = 1'b1;
                DIV_START, DIV_RUN: in_ready = ALLOW_OVERLAP && !uses_hilo;
                default:            in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        op_next       = 6'd0;
        op_valid_next = 1'b0;
        illegal_next  = 1'b0;

        if (accept) begin
            if (is_legal) begin
                op_next       = funct;
                op_valid_next = 1'b1;
            end else begin
                illegal_next = 1'b1;
            end
        end

        case (state_reg)
            IDLE: begin
                if (accept && funct == F_DIVU) begin
                    state_next = DIV_START;
                end
            end
            DIV_START: begin
                state_next = DIV_RUN;
                count_next = 6'd0;
            end
            DIV_RUN: begin
                if (count_reg == LAST_STEP) begin
                    state_next = DIV_WRITE;
                    count_next = 6'd0;
                end else begin
                    count_next = count_reg + 6'd1;
                end
            end
            DIV_WRITE: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            count_reg    <= 6'd0;
            op_reg       <= 6'd0;
            op_valid_reg <= 1'b0;
            illegal_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            op_reg       <= op_next;
            op_valid_reg <= op_valid_next;
            illegal_reg  <= illegal_next;
        end
    end

    assign div_start = (state_reg == DIV_START);
    assign div_step  = (state_reg == DIV_RUN);
    assign hilo_we   = (state_reg == DIV_WRITE);
    assign busy      = (state_reg != IDLE);
    assign div_count = count_reg;
    assign illegal   = illegal_reg;

    // An overlapped op issued in the same cycle as a sequencer marker owns op_out.
    assign op_valid = op_valid_reg || hilo_we;
    assign op_out   = op_valid_reg ? op_reg : (hilo_we ? HILO_OP : 6'd0);

endmodule
